// File: rtl/mpa_dbg_burst_ctrl_if.sv
// Bundle of the host command/stream signals and the core debug port seen by
// mpa_dbg_burst_ctrl. The slave modport is the controller's view, the master
// modport is the host/core side. With MPA_DBG_CKSUM_EN defined the bundle also
// carries the running burst checksum.
interface mpa_dbg_burst_ctrl_if #(
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned ADDRESS_WIDTH = 32,
  parameter int unsigned LEN_WIDTH     = 8
);
  // Command channel
  logic                     cmd_valid;
  logic                     cmd_ready;
  logic                     cmd_write;
  logic [1:0]               cmd_func;
  logic [ADDRESS_WIDTH-1:0] cmd_addr;
  logic [LEN_WIDTH-1:0]     cmd_len;
  // Write and read data streams
  logic [DATA_WIDTH-1:0]    wr_data;
  logic                     wr_valid;
  logic                     wr_ready;
  logic [DATA_WIDTH-1:0]    rd_data;
  logic                     rd_valid;
  logic                     rd_ready;
  // Core debug port
  logic                     dbg_mem_debug;
  logic [1:0]               dbg_func;
  logic [ADDRESS_WIDTH-1:0] dbg_addr;
  logic [DATA_WIDTH-1:0]    dbg_din;
  logic                     dbg_we;
  logic                     dbg_re;
  logic [DATA_WIDTH-1:0]    dbg_dout;
  // Status
  logic                     busy;
  logic                     done;
  logic                     err;
`ifdef MPA_DBG_CKSUM_EN
  logic [DATA_WIDTH-1:0]    cksum;
`endif

  modport slave (
    input  cmd_valid, cmd_write, cmd_func, cmd_addr, cmd_len,
    input  wr_data, wr_valid, rd_ready, dbg_dout,
    output cmd_ready, wr_ready, rd_data, rd_valid,
    output dbg_mem_debug, dbg_func, dbg_addr, dbg_din, dbg_we, dbg_re,
    output busy, done, err
`ifdef MPA_DBG_CKSUM_EN
    , output cksum
`endif
  );

  modport master (
    output cmd_valid, cmd_write, cmd_func, cmd_addr, cmd_len,
    output wr_data, wr_valid, rd_ready, dbg_dout,
    input  cmd_ready, wr_ready, rd_data, rd_valid,
    input  dbg_mem_debug, dbg_func, dbg_addr, dbg_din, dbg_we, dbg_re,
    input  busy, done, err
`ifdef MPA_DBG_CKSUM_EN
    , input cksum
`endif
  );
endinterface

// File: rtl/mpa_dbg_burst_ctrl.sv
// Burst sequencer for the mpa_mips_32 memory debug port. Takes one command
// (target memory, start address, word count, direction), range-checks it and
// then runs the whole burst, streaming write words in and read words out over
// valid/ready handshakes.
// Optional feature: define MPA_DBG_CKSUM_EN to add a modulo-2^DATA_WIDTH sum of
// all words transferred in the current burst (bus.cksum).
module mpa_dbg_burst_ctrl #(
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned ADDRESS_WIDTH = 32,
  parameter int unsigned LEN_WIDTH     = 8,
  parameter int unsigned IM_CAPACITY   = 32,
  parameter int unsigned DM_CAPACITY   = 32,
  parameter int unsigned MR_CAPACITY   = 32
) (
  input logic              CLK,
  input logic              HW_RST,
  mpa_dbg_burst_ctrl_if.slave bus
);

  // IM/DM are byte addressed, MR is word indexed.
  localparam int unsigned ByteStride = DATA_WIDTH / 8;

  typedef enum logic [2:0] {
    StIdle,
    StWrWait,
    StWrIssue,
    StRdIssue,
    StRdCap,
    StRdOut,
    StDone
  } state_e;

  state_e                   state_q;
  logic [1:0]               func_q;
  logic [ADDRESS_WIDTH-1:0] addr_q;
  logic [ADDRESS_WIDTH-1:0] stride_q;
  logic [LEN_WIDTH-1:0]     remaining_q;
  logic [DATA_WIDTH-1:0]    din_q;
  logic [DATA_WIDTH-1:0]    rd_data_q;
  logic                     we_q;
  logic                     re_q;
  logic                     rd_valid_q;
  logic                     wr_ready_q;
  logic                     cmd_ready_q;
  logic                     busy_q;
  logic                     done_q;
  logic                     err_q;
  logic                     mem_debug_q;
`ifdef MPA_DBG_CKSUM_EN
  logic [DATA_WIDTH-1:0]    cksum_q;
`endif

  // Decode of the offered command: word index, stride and capacity check.
  logic [ADDRESS_WIDTH-1:0] word_idx;
  logic [ADDRESS_WIDTH-1:0] stride_sel;
  logic [ADDRESS_WIDTH:0]   cap_sel;
  logic [ADDRESS_WIDTH:0]   end_idx;
  logic                     range_err;

  // Range check of the offered command against the selected memory depth.
  always_comb begin
    word_idx   = bus.cmd_addr / ADDRESS_WIDTH'(ByteStride);
    stride_sel = ADDRESS_WIDTH'(ByteStride);
    cap_sel    = '0;
    case (bus.cmd_func)
      2'd1: cap_sel = (ADDRESS_WIDTH+1)'(IM_CAPACITY);
      2'd2: cap_sel = (ADDRESS_WIDTH+1)'(DM_CAPACITY);
      2'd3: begin
        cap_sel    = (ADDRESS_WIDTH+1)'(MR_CAPACITY);
        word_idx   = bus.cmd_addr;
        stride_sel = ADDRESS_WIDTH'(1);
      end
      default: cap_sel = '0;
    endcase
    // One extra bit so index + len cannot wrap and sneak past the check.
    end_idx   = {1'b0, word_idx} + (ADDRESS_WIDTH+1)'(bus.cmd_len);
    range_err = (bus.cmd_func == 2'd0) || (end_idx > cap_sel);
  end

  // Burst sequencer with all outputs registered alongside the state.
  always_ff @(posedge CLK or posedge HW_RST) begin
    if (HW_RST) begin
      state_q     <= StIdle;
      func_q      <= 2'd0;
      addr_q      <= '0;
      stride_q    <= '0;
      remaining_q <= '0;
      din_q       <= '0;
      rd_data_q   <= '0;
      we_q        <= 1'b0;
      re_q        <= 1'b0;
      rd_valid_q  <= 1'b0;
      wr_ready_q  <= 1'b0;
      cmd_ready_q <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      mem_debug_q <= 1'b0;
`ifdef MPA_DBG_CKSUM_EN
      cksum_q     <= '0;
`endif
    end else begin
      case (state_q)
        StIdle: begin
          if (bus.cmd_valid) begin
            func_q      <= bus.cmd_func;
            addr_q      <= bus.cmd_addr;
            stride_q    <= stride_sel;
            remaining_q <= bus.cmd_len;
            err_q       <= 1'b0;
            cmd_ready_q <= 1'b0;
            busy_q      <= 1'b1;
            mem_debug_q <= 1'b1;
`ifdef MPA_DBG_CKSUM_EN
            cksum_q     <= '0;
`endif
            if (range_err) begin
              // Rejected command: report and finish without touching the port.
              err_q   <= 1'b1;
              done_q  <= 1'b1;
              state_q <= StDone;
            end else if (bus.cmd_len == '0) begin
              done_q  <= 1'b1;
              state_q <= StDone;
            end else if (bus.cmd_write) begin
              wr_ready_q <= 1'b1;
              state_q    <= StWrWait;
            end else begin
              re_q    <= 1'b1;
              state_q <= StRdIssue;
            end
          end
        end

        StWrWait: begin
          if (bus.wr_valid) begin
            wr_ready_q <= 1'b0;
            din_q      <= bus.wr_data;
            we_q       <= 1'b1;
            state_q    <= StWrIssue;
          end
        end

        StWrIssue: begin
          we_q        <= 1'b0;
          remaining_q <= remaining_q - LEN_WIDTH'(1);
          addr_q      <= addr_q + stride_q;
`ifdef MPA_DBG_CKSUM_EN
          cksum_q     <= cksum_q + din_q;
`endif
          if (remaining_q != LEN_WIDTH'(1)) begin
            wr_ready_q <= 1'b1;
            state_q    <= StWrWait;
          end else begin
            done_q  <= 1'b1;
            state_q <= StDone;
          end
        end

        // dbg_re was raised on entry; hold it and the address one more cycle.
        StRdIssue: begin
          state_q <= StRdCap;
        end

        StRdCap: begin
          re_q       <= 1'b0;
          rd_data_q  <= bus.dbg_dout;
          rd_valid_q <= 1'b1;
`ifdef MPA_DBG_CKSUM_EN
          cksum_q    <= cksum_q + bus.dbg_dout;
`endif
          state_q    <= StRdOut;
        end

        StRdOut: begin
          if (bus.rd_ready) begin
            rd_valid_q  <= 1'b0;
            remaining_q <= remaining_q - LEN_WIDTH'(1);
            addr_q      <= addr_q + stride_q;
            if (remaining_q != LEN_WIDTH'(1)) begin
              re_q    <= 1'b1;
              state_q <= StRdIssue;
            end else begin
              done_q  <= 1'b1;
              state_q <= StDone;
            end
          end
        end

        // Single done pulse, then return the port to its quiet idle values.
        StDone: begin
          done_q      <= 1'b0;
          busy_q      <= 1'b0;
          mem_debug_q <= 1'b0;
          func_q      <= 2'd0;
          addr_q      <= '0;
          din_q       <= '0;
          rd_data_q   <= '0;
          cmd_ready_q <= 1'b1;
          state_q     <= StIdle;
        end

        default: begin
          we_q        <= 1'b0;
          re_q        <= 1'b0;
          rd_valid_q  <= 1'b0;
          wr_ready_q  <= 1'b0;
          done_q      <= 1'b0;
          busy_q      <= 1'b0;
          mem_debug_q <= 1'b0;
          func_q      <= 2'd0;
          cmd_ready_q <= 1'b1;
          state_q     <= StIdle;
        end
      endcase
    end
  end

  assign bus.cmd_ready     = cmd_ready_q;
  assign bus.wr_ready      = wr_ready_q;
  assign bus.rd_data       = rd_data_q;
  assign bus.rd_valid      = rd_valid_q;
  assign bus.dbg_mem_debug = mem_debug_q;
  assign bus.dbg_func      = func_q;
  assign bus.dbg_addr      = addr_q;
  assign bus.dbg_din       = din_q;
  assign bus.dbg_we        = we_q;
  assign bus.dbg_re        = re_q;
  assign bus.busy          = busy_q;
  assign bus.done          = done_q;
  assign bus.err           = err_q;
`ifdef MPA_DBG_CKSUM_EN
  assign bus.cksum         = cksum_q;
`endif

endmodule

// File: tb/tb_mpa_dbg_burst_ctrl.sv
// Directed bench for mpa_dbg_burst_ctrl with a small model of the core's
// IM/DM/MR arrays behind the debug port.
module tb_mpa_dbg_burst_ctrl;

  logic CLK = 1'b0;
  logic HW_RST = 1'b1;

  mpa_dbg_burst_ctrl_if #(.DATA_WIDTH(32), .ADDRESS_WIDTH(32), .LEN_WIDTH(8)) bus ();

  mpa_dbg_burst_ctrl #(
    .DATA_WIDTH(32), .ADDRESS_WIDTH(32), .LEN_WIDTH(8),
    .IM_CAPACITY(32), .DM_CAPACITY(32), .MR_CAPACITY(32)
  ) dut (
    .CLK(CLK),
    .HW_RST(HW_RST),
    .bus(bus)
  );

  always #5 CLK = ~CLK;

  int total = 0;
  int bad = 0;

  // Core memory model: index 1 = IM, 2 = DM, 3 = MR.
  bit [31:0] core_mem [4][32];

  function automatic int mem_ix(input logic [1:0] f, input logic [31:0] a);
    logic [31:0] w;
    w = (f == 2'd3) ? a : (a >> 2);
    if (f == 2'd0 || w > 32'd31) return -1;
    return int'(w);
  endfunction

  always @(posedge CLK) begin
    if (bus.dbg_we && mem_ix(bus.dbg_func, bus.dbg_addr) >= 0)
      core_mem[bus.dbg_func][mem_ix(bus.dbg_func, bus.dbg_addr)] <= bus.dbg_din;
    if (bus.dbg_re && mem_ix(bus.dbg_func, bus.dbg_addr) >= 0)
      bus.dbg_dout <= core_mem[bus.dbg_func][mem_ix(bus.dbg_func, bus.dbg_addr)];
    else
      bus.dbg_dout <= '0;
  end

  // Port activity log, sampled shortly after each rising edge.
  logic [31:0] we_addr_q [$];
  logic [31:0] we_din_q [$];
  logic [31:0] re_addr_q [$];
  int re_cycles = 0;
  int overlap = 0;
  logic re_prev = 1'b0;

  always @(posedge CLK) begin
    #2;
    if (bus.dbg_we) begin
      we_addr_q.push_back(bus.dbg_addr);
      we_din_q.push_back(bus.dbg_din);
    end
    if (bus.dbg_re) re_cycles++;
    if (bus.dbg_re && !re_prev) re_addr_q.push_back(bus.dbg_addr);
    if (bus.dbg_we && bus.dbg_re) overlap++;
    re_prev = bus.dbg_re;
  end

  logic [31:0] wr_words [$];
  logic [31:0] rd_q [$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_cmd_ready"}, 64'(bus.cmd_ready), 64'd1);
    chk({tag, "_busy"}, 64'(bus.busy), 64'd0);
    chk({tag, "_done"}, 64'(bus.done), 64'd0);
    chk({tag, "_wr_ready"}, 64'(bus.wr_ready), 64'd0);
    chk({tag, "_rd_valid"}, 64'(bus.rd_valid), 64'd0);
    chk({tag, "_rd_data"}, 64'(bus.rd_data), 64'd0);
    chk({tag, "_mem_debug"}, 64'(bus.dbg_mem_debug), 64'd0);
    chk({tag, "_func"}, 64'(bus.dbg_func), 64'd0);
    chk({tag, "_addr"}, 64'(bus.dbg_addr), 64'd0);
    chk({tag, "_din"}, 64'(bus.dbg_din), 64'd0);
    chk({tag, "_we"}, 64'(bus.dbg_we), 64'd0);
    chk({tag, "_re"}, 64'(bus.dbg_re), 64'd0);
  endtask

  // Offers one command for a single cycle; returns at the negedge after accept.
  task automatic send_cmd(input bit w, input logic [1:0] f, input logic [31:0] a,
                          input logic [7:0] l);
    @(negedge CLK);
    bus.cmd_write = w;
    bus.cmd_func  = f;
    bus.cmd_addr  = a;
    bus.cmd_len   = l;
    bus.cmd_valid = 1'b1;
    @(negedge CLK);
    bus.cmd_valid = 1'b0;
  endtask

  // Feeds wr_words with wr_valid held high; cyc = cycles from accept to done.
  task automatic run_write(output int cyc, output bit ok);
    int k = 0;
    cyc = 0;
    ok = 1'b0;
    bus.wr_valid = 1'b1;
    while (cyc < 1000) begin
      if (bus.done) begin
        ok = 1'b1;
        break;
      end
      if (bus.wr_ready && k < wr_words.size()) begin
        bus.wr_data = wr_words[k];
        k++;
      end
      @(negedge CLK);
      cyc++;
    end
    bus.wr_valid = 1'b0;
  endtask

  // Collects read words, holding rd_ready low for 'stall' cycles per word.
  task automatic run_read(input int stall, output int cyc, output bit ok);
    int waitc = 0;
    logic [31:0] held = '0;
    cyc = 0;
    ok = 1'b0;
    rd_q.delete();
    while (cyc < 2000) begin
      if (bus.done) begin
        ok = 1'b1;
        break;
      end
      bus.rd_ready = 1'b0;
      if (bus.rd_valid) begin
        if (waitc == 0) held = bus.rd_data;
        else begin
          chk("stall_rd_data", 64'(bus.rd_data), 64'(held));
          chk("stall_no_re", 64'(bus.dbg_re), 64'd0);
        end
        if (waitc == stall) begin
          bus.rd_ready = 1'b1;
          rd_q.push_back(bus.rd_data);
          waitc = 0;
        end else begin
          waitc++;
        end
      end
      @(negedge CLK);
      cyc++;
    end
    bus.rd_ready = 1'b0;
  endtask

  initial begin
    int cyc;
    bit ok;
    int we_base;
    int re_base;
    int rec_base;
    int lim;

    bus.cmd_valid = 1'b0;
    bus.cmd_write = 1'b0;
    bus.cmd_func  = 2'd0;
    bus.cmd_addr  = '0;
    bus.cmd_len   = '0;
    bus.wr_data   = '0;
    bus.wr_valid  = 1'b0;
    bus.rd_ready  = 1'b0;

    // Reset state
    repeat (2) @(negedge CLK);
    chk_idle("reset");
    chk("reset_err", 64'(bus.err), 64'd0);
    HW_RST = 1'b0;
    @(negedge CLK);

    // IM write burst, 32 words, wr_valid always high
    wr_words.delete();
    for (int i = 0; i < 32; i++) wr_words.push_back(32'(i));
    we_base = we_addr_q.size();
    send_cmd(1'b1, 2'd1, 32'd0, 8'd32);
    chk("acc_busy", 64'(bus.busy), 64'd1);
    chk("acc_mem_debug", 64'(bus.dbg_mem_debug), 64'd1);
    chk("acc_func", 64'(bus.dbg_func), 64'd1);
    chk("acc_cmd_ready", 64'(bus.cmd_ready), 64'd0);
    run_write(cyc, ok);
    chk("imw_done", 64'(ok), 64'd1);
    chk("imw_cycles", 64'(cyc), 64'd64);
    chk("imw_err", 64'(bus.err), 64'd0);
    chk("imw_mem_debug_at_done", 64'(bus.dbg_mem_debug), 64'd1);
    chk("imw_count", 64'(we_addr_q.size() - we_base), 64'd32);
    lim = (we_addr_q.size() - we_base < 32) ? we_addr_q.size() - we_base : 32;
    for (int i = 0; i < lim; i++) begin
      chk("imw_addr", 64'(we_addr_q[we_base+i]), 64'(4 * i));
      chk("imw_din", 64'(we_din_q[we_base+i]), 64'(i));
    end
    for (int i = 0; i < 32; i++) chk("imw_mem", 64'(core_mem[1][i]), 64'(i));
    @(negedge CLK);
    chk_idle("after_imw");

    // Preload MR r5..r8, then read them back
    wr_words.delete();
    wr_words.push_back(32'hA5);
    wr_words.push_back(32'hB6);
    wr_words.push_back(32'hC7);
    wr_words.push_back(32'hD8);
    we_base = we_addr_q.size();
    send_cmd(1'b1, 2'd3, 32'd5, 8'd4);
    run_write(cyc, ok);
    chk("mrw_done", 64'(ok), 64'd1);
    chk("mrw_count", 64'(we_addr_q.size() - we_base), 64'd4);
    if (we_addr_q.size() - we_base == 4)
      for (int i = 0; i < 4; i++) chk("mrw_addr", 64'(we_addr_q[we_base+i]), 64'(5 + i));
    @(negedge CLK);
    re_base = re_cycles;
    rec_base = re_addr_q.size();
    send_cmd(1'b0, 2'd3, 32'd5, 8'd4);
    run_read(0, cyc, ok);
    chk("mrr_done", 64'(ok), 64'd1);
    chk("mrr_cycles", 64'(cyc), 64'd12);
    chk("mrr_err", 64'(bus.err), 64'd0);
    chk("mrr_words", 64'(rd_q.size()), 64'd4);
    if (rd_q.size() == 4) begin
      chk("mrr_d0", 64'(rd_q[0]), 64'hA5);
      chk("mrr_d1", 64'(rd_q[1]), 64'hB6);
      chk("mrr_d2", 64'(rd_q[2]), 64'hC7);
      chk("mrr_d3", 64'(rd_q[3]), 64'hD8);
    end
    chk("mrr_re_cycles", 64'(re_cycles - re_base), 64'd8);
    chk("mrr_re_pulses", 64'(re_addr_q.size() - rec_base), 64'd4);
    if (re_addr_q.size() - rec_base == 4)
      for (int i = 0; i < 4; i++) chk("mrr_addr", 64'(re_addr_q[rec_base+i]), 64'(5 + i));
    @(negedge CLK);

    // DM preload at byte 8, then read with rd_ready backpressure
    wr_words.delete();
    wr_words.push_back(32'h11);
    wr_words.push_back(32'h22);
    wr_words.push_back(32'h33);
    send_cmd(1'b1, 2'd2, 32'd8, 8'd3);
    run_write(cyc, ok);
    chk("dmw_done", 64'(ok), 64'd1);
    chk("dmw_mem4", 64'(core_mem[2][4]), 64'h33);
    @(negedge CLK);
    re_base = re_cycles;
    rec_base = re_addr_q.size();
    send_cmd(1'b0, 2'd2, 32'd8, 8'd3);
    run_read(10, cyc, ok);
    chk("bp_done", 64'(ok), 64'd1);
    chk("bp_cycles", 64'(cyc), 64'd39);
    chk("bp_words", 64'(rd_q.size()), 64'd3);
    if (rd_q.size() == 3) begin
      chk("bp_d0", 64'(rd_q[0]), 64'h11);
      chk("bp_d1", 64'(rd_q[1]), 64'h22);
      chk("bp_d2", 64'(rd_q[2]), 64'h33);
    end
    chk("bp_re_cycles", 64'(re_cycles - re_base), 64'd6);
    if (re_addr_q.size() - rec_base == 3) begin
      chk("bp_addr0", 64'(re_addr_q[rec_base]), 64'd8);
      chk("bp_addr2", 64'(re_addr_q[rec_base+2]), 64'd16);
    end else chk("bp_re_pulses", 64'(re_addr_q.size() - rec_base), 64'd3);
    @(negedge CLK);

    // Range error, illegal func, zero length, exact fit
    we_base = we_addr_q.size();
    re_base = re_cycles;
    send_cmd(1'b0, 2'd2, 32'd120, 8'd3);
    chk("rng_done", 64'(bus.done), 64'd1);
    chk("rng_err", 64'(bus.err), 64'd1);
    @(negedge CLK);
    chk("rng_done_pulse", 64'(bus.done), 64'd0);
    chk("rng_err_sticky", 64'(bus.err), 64'd1);
    chk("rng_cmd_ready", 64'(bus.cmd_ready), 64'd1);
    send_cmd(1'b1, 2'd0, 32'd0, 8'd1);
    chk("f0_done", 64'(bus.done), 64'd1);
    chk("f0_err", 64'(bus.err), 64'd1);
    @(negedge CLK);
    send_cmd(1'b0, 2'd3, 32'd30, 8'd3);
    chk("mr_over_err", 64'(bus.err), 64'd1);
    @(negedge CLK);
    chk("rng_no_we", 64'(we_addr_q.size() - we_base), 64'd0);
    chk("rng_no_re", 64'(re_cycles - re_base), 64'd0);
    send_cmd(1'b1, 2'd1, 32'd0, 8'd0);
    chk("len0_done", 64'(bus.done), 64'd1);
    chk("len0_err", 64'(bus.err), 64'd0);
    @(negedge CLK);
    chk("len0_no_we", 64'(we_addr_q.size() - we_base), 64'd0);
    send_cmd(1'b0, 2'd2, 32'd116, 8'd3);
    run_read(0, cyc, ok);
    chk("fit_done", 64'(ok), 64'd1);
    chk("fit_err", 64'(bus.err), 64'd0);
    chk("fit_words", 64'(rd_q.size()), 64'd3);
    @(negedge CLK);

    // Reset during the third word of a 10-word IM write
    wr_words.delete();
    for (int i = 0; i < 10; i++) wr_words.push_back(32'h100 + 32'(i));
    we_base = we_addr_q.size();
    send_cmd(1'b1, 2'd1, 32'd0, 8'd10);
    bus.wr_valid = 1'b1;
    cyc = 0;
    while (cyc < 100 && we_addr_q.size() - we_base < 3) begin
      if (bus.wr_ready) bus.wr_data = wr_words[we_addr_q.size() - we_base];
      @(negedge CLK);
      cyc++;
    end
    chk("mid_reached_word3", 64'(we_addr_q.size() - we_base), 64'd3);
    chk("mid_we_before_rst", 64'(bus.dbg_we), 64'd1);
    HW_RST = 1'b1;
    #1;
    chk_idle("mid_rst");
    chk("mid_rst_err", 64'(bus.err), 64'd0);
    repeat (2) @(negedge CLK);
    HW_RST = 1'b0;
    bus.wr_valid = 1'b0;
    repeat (3) @(negedge CLK);
    chk("mid_no_more_we", 64'(we_addr_q.size() - we_base), 64'd3);
    chk("mid_im3_untouched", 64'(core_mem[1][3]), 64'd3);
    wr_words.delete();
    wr_words.push_back(32'h5A);
    we_base = we_addr_q.size();
    send_cmd(1'b1, 2'd3, 32'd2, 8'd1);
    run_write(cyc, ok);
    chk("post_rst_done", 64'(ok), 64'd1);
    chk("post_rst_err", 64'(bus.err), 64'd0);
    chk("post_rst_count", 64'(we_addr_q.size() - we_base), 64'd1);
    chk("post_rst_mem", 64'(core_mem[3][2]), 64'h5A);
    @(negedge CLK);

`ifdef MPA_DBG_CKSUM_EN
    // Checksum wraps modulo 2^32
    wr_words.delete();
    wr_words.push_back(32'd1);
    wr_words.push_back(32'd2);
    wr_words.push_back(32'hFFFF_FFFF);
    send_cmd(1'b1, 2'd2, 32'd0, 8'd3);
    run_write(cyc, ok);
    chk("ck_wr_done", 64'(ok), 64'd1);
    chk("ck_wr_sum", 64'(bus.cksum), 64'd2);
    @(negedge CLK);
    chk("ck_hold_idle", 64'(bus.cksum), 64'd2);
    send_cmd(1'b0, 2'd2, 32'd0, 8'd3);
    chk("ck_clear_on_accept", 64'(bus.cksum), 64'd0);
    run_read(0, cyc, ok);
    chk("ck_rd_sum", 64'(bus.cksum), 64'd2);
    @(negedge CLK);
`endif

    chk("we_re_overlap", 64'(overlap), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

endmodule
